// File: rtl/wht_blk_sched_if.sv
// Bus bundle between the WHT block scheduler and its environment: two column
// requesters, the shared WHT core, the response channel and the status flags.
// master = environment side (requesters + core), slave = scheduler side.
interface wht_blk_sched_if #(
  parameter int WIDTH0 = 8,
  parameter int WIDTH2 = 13
);
  // Requester 0 column channel
  logic [4*WIDTH0-1:0] req0_col;
  logic                req0_valid;
  logic                req0_ready;

  // Requester 1 column channel
  logic [4*WIDTH0-1:0] req1_col;
  logic                req1_valid;
  logic                req1_ready;

  // Column stream into the WHT core
  logic [4*WIDTH0-1:0] core_blk_o;
  logic                core_blk_valid_o;

  // Row stream out of the WHT core
  logic [4*WIDTH2-1:0] core_pix_i;
  logic                core_ovalid_i;

  // Response channel back to the owning requester
  logic [4*WIDTH2-1:0] rsp_data;
  logic                rsp_valid;
  logic                rsp_id;
  logic                rsp_last;

  // Status
  logic                busy;
  logic                err_o;
  logic                timeout_o;

  modport master (
    output req0_col, req0_valid,
    input  req0_ready,
    output req1_col, req1_valid,
    input  req1_ready,
    input  core_blk_o, core_blk_valid_o,
    output core_pix_i, core_ovalid_i,
    input  rsp_data, rsp_valid, rsp_id, rsp_last,
    input  busy, err_o, timeout_o
  );

  modport slave (
    input  req0_col, req0_valid,
    output req0_ready,
    input  req1_col, req1_valid,
    output req1_ready,
    output core_blk_o, core_blk_valid_o,
    input  core_pix_i, core_ovalid_i,
    output rsp_data, rsp_valid, rsp_id, rsp_last,
    output busy, err_o, timeout_o
  );
endinterface

// File: rtl/wht_blk_sched.sv
// Round-robin scheduler sharing one 4x4 Walsh-Hadamard core between two
// block requesters. One block (4 columns in, 4 rows out) is in flight at a
// time: IDLE grants, ISSUE forwards 4 contiguous columns to the core, DRAIN
// returns the 4 core rows tagged with the owner's ID.
//
// Optional build macro WHT_SCHED_TIMEOUT_EN: adds a drain watchdog that
// abandons a block when the core stalls for TIMEOUT cycles in DRAIN.
// Without it DRAIN waits indefinitely and timeout_o is constant 0.
module wht_blk_sched #(
  parameter int WIDTH0  = 8,
  parameter int WIDTH2  = 13,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  wht_blk_sched_if.slave bus
);

  localparam int COL_W = 4 * WIDTH0;
  localparam int ROW_W = 4 * WIDTH2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;

  // Arbitration
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;

  // Block progress
  logic [1:0]         beat_cnt_q, beat_cnt_d;
  logic [1:0]         row_cnt_q, row_cnt_d;

  // Sticky protocol error
  logic               err_q, err_d;

  // Column register toward the core
  logic [COL_W-1:0]   core_blk_q, core_blk_d;
  logic               core_blk_valid_q, core_blk_valid_d;

  // Response register
  logic [ROW_W-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic               rsp_last_q, rsp_last_d;

  // Granted-requester view and per-cycle events
  logic               sel_valid;
  logic [COL_W-1:0]   sel_col;
  logic               accept;
  logic               drain_done;
  logic               row_accept;
  logic               wd_fire;

  // Mux the granted requester onto a single column channel
  always_comb begin
    sel_valid = bus.req0_valid;
    sel_col   = bus.req0_col;
    if (grant_q) begin
      sel_valid = bus.req1_valid;
      sel_col   = bus.req1_col;
    end
  end

  // Ready is high for the whole ISSUE state, so valid alone decides acceptance
  assign accept     = (state_q == S_ISSUE) && sel_valid;
  assign row_accept = (state_q == S_DRAIN) && bus.core_ovalid_i && !drain_done;

`ifdef WHT_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;

  // DRAIN finishes after the rsp_last beat has been driven or the watchdog fired
  assign drain_done = rsp_last_q || timeout_q;

  assign wd_fire = (state_q == S_DRAIN) && !drain_done && !bus.core_ovalid_i &&
                   (wd_cnt_q == WD_W'(TIMEOUT - 1));

  // Watchdog counts idle DRAIN cycles; any core row restarts it
  always_comb begin
    wd_cnt_d  = '0;
    timeout_d = wd_fire;
    if ((state_q == S_DRAIN) && !drain_done && !bus.core_ovalid_i) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
  end

  // Watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  // DRAIN finishes once the rsp_last beat has been driven
  assign drain_done = rsp_last_q;
  assign wd_fire    = 1'b0;
  // No watchdog in this build; the comparison is constant 0 for any legal TIMEOUT
  assign bus.timeout_o = (TIMEOUT < 0);
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; no DRAIN->ISSUE bypass, every grant goes through IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (accept && (beat_cnt_q == 2'd3)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    bus.req0_ready = (state_q == S_ISSUE) && !grant_q;
    bus.req1_ready = (state_q == S_ISSUE) && grant_q;
    bus.busy       = (state_q != S_IDLE);
  end

  // Arbitration, beat/row bookkeeping, column and response capture, error flag
  always_comb begin
    grant_d          = grant_q;
    last_grant_d     = last_grant_q;
    beat_cnt_d       = beat_cnt_q;
    row_cnt_d        = row_cnt_q;
    err_d            = err_q;
    core_blk_d       = core_blk_q;
    core_blk_valid_d = 1'b0;
    rsp_data_d       = rsp_data_q;
    rsp_valid_d      = 1'b0;
    rsp_id_d         = rsp_id_q;
    rsp_last_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Counters restart here so an abandoned block leaves nothing behind
        beat_cnt_d = 2'd0;
        row_cnt_d  = 2'd0;
        if (bus.req0_valid && bus.req1_valid) begin
          grant_d      = !last_grant_q;
          last_grant_d = !last_grant_q;
        end else if (bus.req0_valid) begin
          grant_d      = 1'b0;
          last_grant_d = 1'b0;
        end else if (bus.req1_valid) begin
          grant_d      = 1'b1;
          last_grant_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          core_blk_d       = sel_col;
          core_blk_valid_d = 1'b1;
          beat_cnt_d       = beat_cnt_q + 2'd1;
        end else if (beat_cnt_q != 2'd0) begin
          // The core needs 4 back-to-back columns; a hole mid-block is fatal
          // to the result but we still finish the block to stay in step
          err_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (row_accept) begin
          rsp_data_d  = bus.core_pix_i;
          rsp_valid_d = 1'b1;
          rsp_id_d    = grant_q;
          rsp_last_d  = (row_cnt_q == 2'd3);
          row_cnt_d   = row_cnt_q + 2'd1;
        end
      end
      default: ;
    endcase

    // Core rows outside an open DRAIN window are dropped and flagged
    if (bus.core_ovalid_i && !row_accept) begin
      err_d = 1'b1;
    end
    if (wd_fire) begin
      err_d = 1'b1;
    end
  end

  // Control and output registers; everything clears so outputs read 0 after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q          <= 1'b0;
      last_grant_q     <= 1'b1;
      beat_cnt_q       <= 2'd0;
      row_cnt_q        <= 2'd0;
      err_q            <= 1'b0;
      core_blk_q       <= '0;
      core_blk_valid_q <= 1'b0;
      rsp_data_q       <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_id_q         <= 1'b0;
      rsp_last_q       <= 1'b0;
    end else begin
      grant_q          <= grant_d;
      last_grant_q     <= last_grant_d;
      beat_cnt_q       <= beat_cnt_d;
      row_cnt_q        <= row_cnt_d;
      err_q            <= err_d;
      core_blk_q       <= core_blk_d;
      core_blk_valid_q <= core_blk_valid_d;
      rsp_data_q       <= rsp_data_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_id_q         <= rsp_id_d;
      rsp_last_q       <= rsp_last_d;
    end
  end

  assign bus.core_blk_o       = core_blk_q;
  assign bus.core_blk_valid_o = core_blk_valid_q;
  assign bus.rsp_data         = rsp_data_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_id           = rsp_id_q;
  assign bus.rsp_last         = rsp_last_q;
  assign bus.err_o            = err_q;

endmodule

// File: tb/tb_wht_blk_sched.sv
// Directed bench for wht_blk_sched: single block, contention, gap error,
// stray core row, mid-block reset and the drain watchdog (or its absence).
module tb_wht_blk_sched;
  localparam int W0 = 8;
  localparam int W2 = 13;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wht_blk_sched_if #(.WIDTH0(W0), .WIDTH2(W2)) bus ();

  wht_blk_sched #(.WIDTH0(W0), .WIDTH2(W2), .TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Distinct, recognisable row pattern per block/row
  function automatic logic [4*W2-1:0] row_val(input int blk, input int r);
    logic [W2-1:0] b;
    b = W2'(blk * 256 + r * 16);
    return {b + W2'(3), b + W2'(2), b + W2'(1), b};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Feed 4 columns from requester g (already granted, valid already high)
  task automatic issue_block(input logic g, input logic [31:0] base);
    logic [31:0] col;
    for (int i = 0; i < 4; i++) begin
      col = base + 32'h04040404 * i;
      if (g) bus.req1_col = col;
      else   bus.req0_col = col;
      chk("ready_granted", g ? bus.req1_ready : bus.req0_ready, 1'b1);
      tick();
      chk("blk_valid", bus.core_blk_valid_o, 1'b1);
      chk("blk_data", bus.core_blk_o, col);
    end
  endtask

  // Return n rows from the core and check the response beats
  task automatic drain_rows(input int blk, input logic id, input int n);
    for (int r = 0; r < n; r++) begin
      bus.core_pix_i    = row_val(blk, r);
      bus.core_ovalid_i = 1'b1;
      tick();
      chk("rsp_valid", bus.rsp_valid, 1'b1);
      chk("rsp_data", bus.rsp_data, row_val(blk, r));
      chk("rsp_id", bus.rsp_id, id);
      chk("rsp_last", bus.rsp_last, (r == 3));
      chk("busy_drain", bus.busy, 1'b1);
    end
    bus.core_ovalid_i = 1'b0;
  endtask

  initial begin
    logic g;
    rst               = 1'b1;
    bus.req0_col      = '0;
    bus.req0_valid    = 1'b0;
    bus.req1_col      = '0;
    bus.req1_valid    = 1'b0;
    bus.core_pix_i    = '0;
    bus.core_ovalid_i = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_err", bus.err_o, 1'b0);
    chk("rst_timeout", bus.timeout_o, 1'b0);
    chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_ready1", bus.req1_ready, 1'b0);
    chk("rst_blk_valid", bus.core_blk_valid_o, 1'b0);
    chk("rst_blk", bus.core_blk_o, 32'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 52'h0);
    rst = 1'b0;

    // Single block from requester 0
    bus.req0_valid = 1'b1;
    bus.req0_col   = 32'h04030201;
    chk("idle_ready0", bus.req0_ready, 1'b0);
    tick();
    chk("grant_busy", bus.busy, 1'b1);
    chk("grant_ready0", bus.req0_ready, 1'b1);
    chk("grant_ready1", bus.req1_ready, 1'b0);
    chk("grant_blk_valid", bus.core_blk_valid_o, 1'b0);
    issue_block(1'b0, 32'h04030201);
    bus.req0_valid = 1'b0;
    chk("drain_ready0", bus.req0_ready, 1'b0);
    tick();
    chk("blk_valid_end", bus.core_blk_valid_o, 1'b0);
    chk("blk_hold", bus.core_blk_o, 32'h100F0E0D);
    tick();
    tick();
    tick();
    drain_rows(0, 1'b0, 4);
    tick();
    chk("single_busy_end", bus.busy, 1'b0);
    chk("single_rsp_end", bus.rsp_valid, 1'b0);
    chk("single_err", bus.err_o, 1'b0);

    // Contention: both requesters held high for three blocks
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      g = (b == 1);
      tick();
      chk("cont_ready0", bus.req0_ready, !g);
      chk("cont_ready1", bus.req1_ready, g);
      issue_block(g, g ? 32'hB0B1B2B3 : 32'hA0A1A2A3);
      chk("cont_drain_r0", bus.req0_ready, 1'b0);
      chk("cont_drain_r1", bus.req1_ready, 1'b0);
      drain_rows(b + 1, g, 4);
      tick();
      chk("cont_idle", bus.busy, 1'b0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("cont_err", bus.err_o, 1'b0);

    // Gap violation on requester 1 after beat 2
    do_reset();
    chk("gap_err_pre", bus.err_o, 1'b0);
    bus.req1_valid = 1'b1;
    bus.req1_col   = 32'h11111111;
    tick();
    tick();
    chk("gap_b0", bus.core_blk_o, 32'h11111111);
    bus.req1_col = 32'h22222222;
    tick();
    chk("gap_b1", bus.core_blk_o, 32'h22222222);
    chk("gap_err_b1", bus.err_o, 1'b0);
    bus.req1_valid = 1'b0;
    tick();
    chk("gap_hole_valid", bus.core_blk_valid_o, 1'b0);
    chk("gap_err", bus.err_o, 1'b1);
    chk("gap_still_ready", bus.req1_ready, 1'b1);
    bus.req1_valid = 1'b1;
    bus.req1_col   = 32'h33333333;
    tick();
    chk("gap_b2", bus.core_blk_o, 32'h33333333);
    bus.req1_col = 32'h44444444;
    tick();
    chk("gap_b3", bus.core_blk_o, 32'h44444444);
    bus.req1_valid = 1'b0;
    chk("gap_drain_ready", bus.req1_ready, 1'b0);
    drain_rows(5, 1'b1, 4);
    tick();
    chk("gap_err_sticky", bus.err_o, 1'b1);
    chk("gap_busy_end", bus.busy, 1'b0);

    // Stray core row while idle
    do_reset();
    chk("stray_err_pre", bus.err_o, 1'b0);
    bus.core_pix_i    = row_val(9, 0);
    bus.core_ovalid_i = 1'b1;
    tick();
    bus.core_ovalid_i = 1'b0;
    chk("stray_rsp_valid", bus.rsp_valid, 1'b0);
    chk("stray_err", bus.err_o, 1'b1);
    tick();
    chk("stray_busy", bus.busy, 1'b0);

    // Reset in the middle of issuing a block
    do_reset();
    chk("mid_err_clear", bus.err_o, 1'b0);
    bus.req0_valid = 1'b1;
    bus.req0_col   = 32'h55555555;
    tick();
    tick();
    tick();
    chk("mid_two_beats", bus.core_blk_valid_o, 1'b1);
    bus.req1_valid = 1'b1;
    rst = 1'b1;
    tick();
    chk("mid_blk", bus.core_blk_o, 32'h0);
    chk("mid_blk_valid", bus.core_blk_valid_o, 1'b0);
    chk("mid_ready0", bus.req0_ready, 1'b0);
    chk("mid_ready1", bus.req1_ready, 1'b0);
    chk("mid_busy", bus.busy, 1'b0);
    chk("mid_err", bus.err_o, 1'b0);
    chk("mid_rsp_valid", bus.rsp_valid, 1'b0);
    chk("mid_rsp_data", bus.rsp_data, 52'h0);
    chk("mid_rsp_id", bus.rsp_id, 1'b0);
    chk("mid_rsp_last", bus.rsp_last, 1'b0);
    chk("mid_timeout", bus.timeout_o, 1'b0);
    rst = 1'b0;
    tick();
    chk("mid_regrant0", bus.req0_ready, 1'b1);
    chk("mid_regrant1", bus.req1_ready, 1'b0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Core stalls after 2 rows
    do_reset();
    bus.req0_valid = 1'b1;
    tick();
    issue_block(1'b0, 32'h01020304);
    bus.req0_valid = 1'b0;
    tick();
    drain_rows(7, 1'b0, 2);
`ifdef WHT_SCHED_TIMEOUT_EN
    for (int k = 1; k < 64; k++) begin
      tick();
      chk("wd_quiet", bus.timeout_o, 1'b0);
    end
    tick();
    chk("wd_pulse", bus.timeout_o, 1'b1);
    chk("wd_err", bus.err_o, 1'b1);
    chk("wd_no_last", bus.rsp_last, 1'b0);
    tick();
    chk("wd_pulse_end", bus.timeout_o, 1'b0);
    chk("wd_busy", bus.busy, 1'b0);
`else
    for (int k = 0; k < 100; k++) begin
      tick();
    end
    chk("nowd_busy", bus.busy, 1'b1);
    chk("nowd_timeout", bus.timeout_o, 1'b0);
    chk("nowd_err", bus.err_o, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
